// File: rtl/key_loader.sv
// Key-frame loader: accepts A5 + 8 key bytes + XOR checksum, releases the core
// from reset only on a verified key, and locks out after MAX_FAIL bad frames.
module key_loader #(
   parameter int MAX_FAIL = 3,
   parameter int TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        clear,
   output logic [63:0] key,
   output logic        key_valid,
   output logic        core_rst,
   output logic        error,
   output logic [1:0]  fail_count,
   output logic        locked_out,
   output logic [2:0]  state_dbg
);

   // Handshake: a byte transfers on a rising edge only when byte_valid && byte_ready;
   // byte_ready depends on state alone, never on byte_valid.
   typedef enum logic [2:0] {S_IDLE, S_KEY, S_CHK, S_LOADED, S_LOCKOUT} state_t;

   localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          state;
   logic [63:0]     shadow;
   logic [2:0]      byte_cnt;
   logic [GW-1:0]   gap;
   logic [7:0]      csum;
   logic [1:0]      fail_inc;
   logic            accept, timeout_hit, chk_pass, frame_fail, lock_now;

   always_comb begin
      csum = '0;
      for (int i = 0; i < 8; i++) csum = csum ^ shadow[8*i +: 8];
   end

   assign byte_ready  = (state == S_IDLE) || (state == S_KEY) || (state == S_CHK);
   assign accept      = byte_valid && byte_ready;
   assign timeout_hit = !accept && (gap == GW'(TIMEOUT - 1));
   assign chk_pass    = accept && (byte_in == csum);
   assign frame_fail  = ((state == S_KEY) && timeout_hit) ||
                        ((state == S_CHK) && (accept ? !chk_pass : timeout_hit));
   assign fail_inc    = (fail_count >= 2'(MAX_FAIL)) ? 2'(MAX_FAIL) : fail_count + 2'd1;
   assign lock_now    = (fail_inc == 2'(MAX_FAIL));
   assign state_dbg   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         key        <= '0;
         shadow     <= '0;
         key_valid  <= 1'b0;
         core_rst   <= 1'b1;
         error      <= 1'b0;
         fail_count <= '0;
         locked_out <= 1'b0;
         byte_cnt   <= '0;
         gap        <= '0;
      end else begin
         error <= 1'b0;
         // Clear outranks everything except lockout, including a same-edge checksum pass.
         if (clear && (state != S_LOCKOUT)) begin
            state     <= S_IDLE;
            key       <= '0;
            shadow    <= '0;
            key_valid <= 1'b0;
            core_rst  <= 1'b1;
            byte_cnt  <= '0;
            gap       <= '0;
         end else if (frame_fail) begin
            error      <= 1'b1;
            fail_count <= fail_inc;
            shadow     <= '0;
            byte_cnt   <= '0;
            gap        <= '0;
            locked_out <= lock_now;
            state      <= lock_now ? S_LOCKOUT : S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept && (byte_in == 8'hA5)) begin
                     state    <= S_KEY;
                     byte_cnt <= '0;
                     gap      <= '0;
                  end
               end
               S_KEY: begin
                  if (accept) begin
                     shadow <= {shadow[55:0], byte_in};
                     gap    <= '0;
                     if (byte_cnt == 3'd7) state <= S_CHK;
                     else                  byte_cnt <= byte_cnt + 3'd1;
                  end else begin
                     gap <= gap + GW'(1);
                  end
               end
               S_CHK: begin
                  if (chk_pass) begin
                     key        <= shadow;
                     key_valid  <= 1'b1;
                     core_rst   <= 1'b0;
                     fail_count <= '0;
                     gap        <= '0;
                     state      <= S_LOADED;
                  end else begin
                     gap <= gap + GW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: directed table, hand sequences for timeout/clear/lockout/reset,
// and randomized frames checked every cycle against a queue-based frame model.
module tb_key_loader;

   localparam int MAX_FAIL = 3;
   localparam int TIMEOUT  = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        clear;
   logic [63:0] key;
   logic        key_valid;
   logic        core_rst;
   logic        error;
   logic [1:0]  fail_count;
   logic        locked_out;
   logic [2:0]  state_dbg;

   always #5 clk = ~clk;

   key_loader #(.MAX_FAIL(MAX_FAIL), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .clear(clear), .key(key), .key_valid(key_valid),
      .core_rst(core_rst), .error(error), .fail_count(fail_count),
      .locked_out(locked_out), .state_dbg(state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: phase 0 hunting header, 1 in frame, 2 loaded, 3 locked out.
   int          m_phase;
   logic [7:0]  fq[$];
   int          m_gap;
   int          m_fails;
   logic [63:0] m_key;
   bit          m_kv;
   bit          m_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; fq.delete(); m_gap = 0; m_fails = 0; m_key = '0; m_kv = 0; m_err = 0;
   endtask

   task automatic model_fail();
      m_err = 1;
      if (m_fails < MAX_FAIL) m_fails++;
      m_phase = (m_fails == MAX_FAIL) ? 3 : 0;
      fq.delete();
      m_gap = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] b, input bit c);
      bit acc;
      logic [7:0] x;
      m_err = 0;
      acc = v && (m_phase <= 1);
      if (c && m_phase != 3) begin
         m_phase = 0; fq.delete(); m_key = '0; m_kv = 0; m_gap = 0;
      end else if (m_phase == 0) begin
         if (acc && b == 8'hA5) begin m_phase = 1; fq.delete(); m_gap = 0; end
      end else if (m_phase == 1) begin
         if (acc) begin
            m_gap = 0;
            if (fq.size() < 8) fq.push_back(b);
            else begin
               x = 8'h00;
               foreach (fq[i]) x = x ^ fq[i];
               if (b == x) begin
                  for (int i = 0; i < 8; i++) m_key[63 - 8*i -: 8] = fq[i];
                  m_kv = 1; m_fails = 0; m_phase = 2; fq.delete();
               end else model_fail();
            end
         end else begin
            m_gap++;
            if (m_gap == TIMEOUT) model_fail();
         end
      end
   endtask

   task automatic compare_all();
      check("key",        key,        m_kv ? m_key : 64'h0);
      check("key_valid",  key_valid,  m_kv);
      check("core_rst",   core_rst,   !m_kv);
      check("error",      error,      m_err);
      check("fail_count", fail_count, m_fails);
      check("locked_out", locked_out, m_phase == 3);
      check("byte_ready", byte_ready, m_phase <= 1);
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit c);
      byte_valid = v; byte_in = b; clear = c;
      model_step(v, b, c);
      @(posedge clk); #1;
      compare_all();
      byte_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_key"},    key,        64'h0);
      check({tag, "_kv"},     key_valid,  1'b0);
      check({tag, "_corerst"},core_rst,   1'b1);
      check({tag, "_err"},    error,      1'b0);
      check({tag, "_fail"},   fail_count, 2'd0);
      check({tag, "_lock"},   locked_out, 1'b0);
      check({tag, "_ready"},  byte_ready, 1'b1);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check_reset_vals(tag);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] k, input logic [7:0] chk_flip);
      logic [7:0] x;
      x = 8'h00;
      step(1, 8'hA5, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, k[63 - 8*i -: 8], 0);
         x = x ^ k[63 - 8*i -: 8];
      end
      step(1, x ^ chk_flip, 0);
   endtask

   typedef struct {
      logic       v;
      logic [7:0] b;
      logic       ekv;
      logic       eerr;
      logic [1:0] efail;
      logic       erdy;
   } vec_t;

   vec_t tbl[20];
   logic [7:0] frame_bytes[10];

   initial begin
      logic [63:0] rk;
      logic [7:0]  x;
      int          kind, nb;

      // Bad-checksum frame followed by the good frame; expectations written out explicitly.
      frame_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      for (int i = 0; i < 10; i++) begin
         tbl[i]      = '{v: 1'b1, b: frame_bytes[i], ekv: 1'b0, eerr: 1'b0, efail: 2'd0, erdy: 1'b1};
         tbl[i + 10] = '{v: 1'b1, b: frame_bytes[i], ekv: 1'b0, eerr: 1'b0, efail: 2'd1, erdy: 1'b1};
      end
      tbl[9].b     = 8'h89;
      tbl[9].eerr  = 1'b1;
      tbl[9].efail = 2'd1;
      tbl[19]      = '{v: 1'b1, b: 8'h88, ekv: 1'b1, eerr: 1'b0, efail: 2'd0, erdy: 1'b0};

      rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].v, tbl[i].b, 0);
         check($sformatf("tbl%0d_kv", i),    key_valid,  tbl[i].ekv);
         check($sformatf("tbl%0d_err", i),   error,      tbl[i].eerr);
         check($sformatf("tbl%0d_fail", i),  fail_count, tbl[i].efail);
         check($sformatf("tbl%0d_ready", i), byte_ready, tbl[i].erdy);
      end
      check("good_key", key, 64'h1122334455667788);
      check("good_corerst", core_rst, 1'b0);

      // Clear of a loaded key.
      step(0, 8'h00, 1);
      check("clr_key", key, 64'h0);
      check("clr_kv", key_valid, 1'b0);
      check("clr_corerst", core_rst, 1'b1);

      // Gap of 254 idle cycles survives; 255 aborts the frame.
      step(1, 8'hA5, 0); step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
      repeat (254) step(0, 8'h00, 0);
      check("gap254_fail", fail_count, 2'd0);
      step(1, 8'h44, 0);
      repeat (254) step(0, 8'h00, 0);
      check("gap_pre_err", error, 1'b0);
      step(0, 8'h00, 0);
      check("timeout_err", error, 1'b1);
      check("timeout_fail", fail_count, 2'd1);
      check("timeout_ready", byte_ready, 1'b1);
      step(0, 8'h00, 0);
      check("timeout_pulse", error, 1'b0);

      // Clear on the checksum-pass edge wins.
      for (int i = 0; i < 9; i++) step(1, frame_bytes[i], 0);
      step(1, 8'h88, 1);
      check("clrpass_kv", key_valid, 1'b0);
      check("clrpass_key", key, 64'h0);
      check("clrpass_fail", fail_count, 2'd1);
      check("clrpass_ready", byte_ready, 1'b1);

      // Stray bytes before a header are discarded.
      do_reset("rst1");
      step(1, 8'h00, 0); step(1, 8'hFF, 0);
      check("stray_fail", fail_count, 2'd0);
      check("stray_err", error, 1'b0);

      // Three bad frames lock out; good frame and clear are ignored.
      for (int f = 0; f < 3; f++) send_frame(64'h1122334455667788, 8'h01);
      check("lock_out", locked_out, 1'b1);
      check("lock_ready", byte_ready, 1'b0);
      check("lock_fail", fail_count, 2'd3);
      send_frame(64'h1122334455667788, 8'h00);
      check("lock_kv", key_valid, 1'b0);
      step(0, 8'h00, 1);
      check("lock_clear", locked_out, 1'b1);
      do_reset("rst_lock");

      // Asynchronous reset mid-frame, at the 5th key byte.
      for (int i = 0; i < 5; i++) step(1, frame_bytes[i], 0);
      byte_valid = 1'b1; byte_in = 8'h55;
      #2;
      do_reset("rst_mid");
      byte_valid = 1'b0;
      step(1, 8'h00, 0);

      // Asynchronous reset while loaded.
      send_frame(64'hDEADBEEF01234567, 8'h00);
      check("load2_kv", key_valid, 1'b1);
      #2;
      do_reset("rst_loaded");

      // Randomized frames against the model.
      for (int f = 0; f < 300; f++) begin
         if (m_phase == 3) do_reset("rst_rand");
         else if (m_phase == 2) begin
            repeat ($urandom_range(0, 3)) step(1, 8'($urandom), 0);
            step($urandom_range(0, 1), 8'($urandom), 1);
         end else begin
            kind = $urandom_range(0, 9);
            rk   = {$urandom, $urandom};
            x    = 8'h00;
            nb   = (kind == 3) ? $urandom_range(0, 8) : 9;
            step(1, (kind == 0) ? 8'($urandom_range(0, 164)) : 8'hA5, 0);
            for (int i = 0; i < nb; i++) begin
               repeat ($urandom_range(0, 2)) step(0, 8'($urandom), 0);
               if (i < 8) begin
                  x = x ^ rk[63 - 8*i -: 8];
                  step(1, rk[63 - 8*i -: 8], ($urandom_range(0, 149) == 0));
               end else begin
                  step(1, (kind == 1 || kind == 2) ? (x ^ 8'($urandom_range(1, 255))) : x,
                       ($urandom_range(0, 149) == 0));
               end
            end
            if (kind == 3) repeat (TIMEOUT + 1) step(0, 8'h00, 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 The block SHALL have parameter MAX_FAIL, default 3, meaning the number of failed frames before permanent lockout.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum idle cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 byte_in  input  8  key-frame byte from the provisioning source.
REQ-006 byte_valid  input  1  byte_in holds a valid byte.
REQ-007 byte_ready  output  1  the block can accept a byte this cycle.
REQ-008 clear  input  1  synchronous request to zeroize the key.
REQ-009 key  output  64  key delivered to the processor core's locked units.
REQ-010 key_valid  output  1  key holds a verified value.
REQ-011 core_rst  output  1  active-high hold-reset to the processor core.
REQ-012 error  output  1  one-cycle pulse on each failed frame.
REQ-013 fail_count  output  2  number of failed frames since the last successful load.
REQ-014 locked_out  output  1  the block is in permanent lockout.

Function
REQ-015 A byte SHALL be accepted only on a rising edge where byte_valid and byte_ready are both 1.
REQ-016 A frame SHALL be 10 bytes: header 0xA5, then 8 key bytes MSB first (key[63:56] first), then a checksum equal to the XOR of the 8 key bytes.
REQ-017 States: IDLE, KEY, CHK, LOADED, LOCKOUT; byte_ready SHALL be 1 in IDLE, KEY and CHK, and 0 in LOADED and LOCKOUT.
REQ-018 In IDLE, header 0xA5 -> KEY with byte counter=0; any other byte SHALL be discarded with no failure counted.
REQ-019 KEY SHALL shift accepted bytes into a 64-bit shadow register and, on the 8th byte, go to CHK.
REQ-020 In CHK, on an accepted byte that matches the checksum: next edge key<=shadow, key_valid<=1, core_rst<=0, fail_count<=0, state LOADED; latency is 1 cycle after checksum acceptance.
REQ-021 On a checksum mismatch: error=1 for one cycle, fail_count+1, shadow zeroed, and return to IDLE; when fail_count reaches MAX_FAIL, go to LOCKOUT instead.
REQ-022 In KEY or CHK, TIMEOUT consecutive cycles without an accepted byte SHALL abort the frame and count as a failure, handled exactly as REQ-021.
REQ-023 The gap counter SHALL reset on every accepted byte and SHALL NOT run in IDLE, LOADED or LOCKOUT.
REQ-024 The key output SHALL stay 0 whenever key_valid=0; shadow contents SHALL never appear on the key output before checksum pass.
REQ-025 core_rst SHALL be a registered output equal to NOT key_valid.
REQ-026 clear=1 in IDLE, KEY, CHK or LOADED: next edge key<=0, key_valid<=0, core_rst<=1, shadow<=0, state IDLE, no failure counted.
REQ-027 clear SHALL be ignored in LOCKOUT.
REQ-028 If clear and checksum-pass occur on the same edge, clear SHALL win: no load, no fail_count reset.
REQ-029 LOCKOUT SHALL exit only via rst, with locked_out=1, key=0, key_valid=0 and core_rst=1 while in LOCKOUT.
REQ-030 fail_count SHALL saturate at MAX_FAIL.

Reset
REQ-031 rst SHALL immediately, independent of clk, force: state IDLE, key=0, shadow=0, key_valid=0, core_rst=1, error=0, fail_count=0, locked_out=0, byte counter=0, gap counter=0.
REQ-032 rst asserted mid-frame or in LOADED SHALL discard all key material; byte_ready SHALL be 1 on the first edge after rst deasserts.

Verification
REQ-033 Good frame A5,11,22,33,44,55,66,77,88,88 -> one cycle after the last byte: key=0x1122334455667788, key_valid=1, core_rst=0, byte_ready=0.
REQ-034 Same frame with checksum 0x89 -> error pulses once, fail_count=1, key=0, core_rst=1, state IDLE; then a good frame -> load succeeds and fail_count=0.
REQ-035 Three consecutive bad frames -> locked_out=1 and byte_ready=0; a good frame and clear are both ignored; rst -> IDLE with locked_out=0.
REQ-036 A5 then 3 key bytes then 255 idle cycles -> error pulse, fail_count=1, IDLE; a 254-cycle gap -> no abort.
REQ-037 Loaded key, then clear=1 -> next edge key=0, key_valid=0, core_rst=1; clear on the checksum-pass edge -> no load.
REQ-038 Stray bytes 00,FF before the header -> ignored, fail_count=0; rst asserted at the 5th key byte -> all outputs at reset values asynchronously.
